gelato_l2_responder: RTL
========================

// Module: gelato_l2_responder
// PURPOSE
//  Memory-side end of the SM's two L2 cache channels (instruction fetch, data load/store).
//  Arbitrates both request streams onto one word-wide backing SRAM inside the block.
//  Returns each response on the originating channel after a fixed pipeline latency.
//  Instantiated in the GPU top next to each gelato_sm; it replaces off-chip memory in the system bench.
// PARAMETERS
//  ADDR_W   32    byte-address width of both channels
//  DATA_W   32    word width; must be 32
//  DEPTH    4096  backing words; power of two; index = addr[2 +: $clog2(DEPTH)]
//  LATENCY  4     cycles from request acceptance to resp_valid; range 1..8
// PORTS
//  clk             in   1       clock
//  rst_n           in   1       asynchronous active-low reset
//  rdy             in   1       global enable; low = freeze all state
//  inst_req_valid  in   1       instruction read request
//  inst_req_addr   in   ADDR_W  byte address; bits [1:0] ignored
//  inst_req_ready  out  1       request accepted this cycle
//  inst_resp_valid out  1       one-cycle pulse, read data valid
//  inst_resp_data  out  DATA_W  read word
//  data_req_valid  in   1       data request
//  data_req_write  in   1       1 = store, 0 = load
//  data_req_addr   in   ADDR_W  byte address; bits [1:0] ignored
//  data_req_wdata  in   DATA_W  store word
//  data_req_wstrb  in   4       store byte enables
//  data_req_ready  out  1       request accepted this cycle
//  data_resp_valid out  1       one-cycle pulse: load data or store ack
//  data_resp_data  out  DATA_W  load word; post-write word for stores
// BEHAVIOUR
//  - Reset: all outputs 0, both channel FSMs IDLE, pipeline empty, rr pointer = DATA (inst wins first tie). SRAM contents are not reset.
//  - Per-channel FSM: IDLE -> BUSY on acceptance; BUSY -> IDLE in the cycle its resp_valid pulses.
//    A BUSY channel is not granted. Each channel has at most one outstanding request.
//  - Acceptance: req_ready = rdy & req_valid & channel IDLE & granted. The request is taken in that cycle.
//    The requester holds valid and payload stable until ready. A new request may be accepted on
//    the same channel in the cycle after resp_valid.
//  - Arbitration: one acceptance per cycle. If only one eligible channel is valid, it wins. If both
//    are valid, the channel not granted last wins. The rr pointer updates only on a grant.
//  - Memory: SRAM access happens in the acceptance cycle. Stores write only the bytes enabled in wstrb.
//    A read in a later cycle sees the store. wstrb = 0 is a legal no-write ack.
//  - Latency: the request is accepted at cycle t. With rdy high throughout, resp_valid=1 and resp_data
//    are valid at t+LATENCY. resp_data keeps its value until the next response. A tagged shift
//    pipeline of depth LATENCY carries {valid, channel, word}.
//  - No response backpressure. The SM always sinks a resp_valid pulse.
//  - rdy low: no acceptance, the pipeline and FSMs hold, resp_valid is forced 0, and a pending
//    response is delayed cycle-for-cycle.
//  - Address wrap: index bits above $clog2(DEPTH)+2 are ignored, so accesses alias modulo DEPTH.
//  - Async reset mid-flight: in-flight responses are dropped, FSMs return to IDLE, SRAM keeps prior writes.
// STRUCTURE
//  - gelato_mem_pkg: typedef l2_chan_e {CHAN_INST, CHAN_DATA}; typedef l2_pipe_entry_t
//    {valid, chan, data}; localparam WORD_BYTES = 4.
//  - Sub-module gelato_rr_arbiter2: 2-way round-robin, req[1:0], grant[1:0], advance input.
//  - SRAM is an inferred array in this module. The latency pipeline is inline.
// TESTING
//  - Preload word[0x10]=0xDEADBEEF; inst read 0x40 at t -> inst_resp_valid at t+4, data 0xDEADBEEF, no data_resp.
//  - Data store 0x80 wdata 0x11223344 wstrb 4'b0101 over 0xFFFFFFFF, then load 0x80 -> 0xFF22FF44 on both responses.
//  - Both channels valid every cycle from reset -> grants alternate inst,data,... and each channel waits for its own response before its next grant.
//  - Inst read accepted, rdy low 3 cycles at t+2 -> resp_valid at t+7, exactly one pulse.
//  - DEPTH=4096: store to 0x4000 then load 0x0 -> same word returned (wrap).
//  - Assert rst_n low 2 cycles after acceptance -> no resp_valid afterwards, readys re-assert after release, earlier store persists.

Source files
------------

// File: rtl/gelato_mem_pkg.sv
// Shared types for the L2 responder.
//   l2_chan_e        : which channel a request or response belongs to
//   l2_chan_state_e  : per-channel request state (one outstanding request max)
//   l2_pipe_entry_t  : one slot of the response latency pipeline
//   merge_bytes()    : byte-enable merge of a store word into an existing word
package gelato_mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int WORD_W     = WORD_BYTES * 8;

  typedef enum logic {
    CHAN_INST = 1'b0,
    CHAN_DATA = 1'b1
  } l2_chan_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } l2_chan_state_e;

  typedef struct packed {
    logic              valid;
    l2_chan_e          chan;
    logic [WORD_W-1:0] data;
  } l2_pipe_entry_t;

  function automatic logic [WORD_W-1:0] merge_bytes(
    input logic [WORD_W-1:0]     old_word,
    input logic [WORD_W-1:0]     new_word,
    input logic [WORD_BYTES-1:0] strb
  );
    logic [WORD_W-1:0] w;
    w = old_word;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (strb[b]) w[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/gelato_rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : bit 0 = instruction channel, bit 1 = data channel
//   advance    : a grant was actually taken this cycle; moves the pointer
//   grant[1:0] : one-hot grant (combinational)
// The pointer remembers the last granted channel; on a tie the other one wins.
// Reset value "last = DATA" makes the instruction channel win the first tie.
module gelato_rr_arbiter2
  import gelato_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  l2_chan_e r_last;

  always_comb begin
    if (req == 2'b11) grant = (r_last == CHAN_DATA) ? 2'b01 : 2'b10;
    else              grant = req;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_last <= CHAN_DATA;
    else if (advance) r_last <= grant[1] ? CHAN_DATA : CHAN_INST;
  end

endmodule

// File: rtl/gelato_l2_responder.sv
// Memory-side end of the SM's instruction and data L2 channels.
// Both channels share one word-wide SRAM; each accepted request is answered on
// its own channel exactly LATENCY enabled (rdy-high) cycles later.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   rdy                         : global enable, low freezes all state
//   inst_req_*/inst_resp_*      : instruction read channel
//   data_req_*/data_resp_*      : data load/store channel (store returns post-write word)
module gelato_l2_responder
  import gelato_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              inst_req_valid,
  input  logic [ADDR_W-1:0] inst_req_addr,
  output logic              inst_req_ready,
  output logic              inst_resp_valid,
  output logic [DATA_W-1:0] inst_resp_data,
  input  logic              data_req_valid,
  input  logic              data_req_write,
  input  logic [ADDR_W-1:0] data_req_addr,
  input  logic [DATA_W-1:0] data_req_wdata,
  input  logic [3:0]        data_req_wstrb,
  output logic              data_req_ready,
  output logic              data_resp_valid,
  output logic [DATA_W-1:0] data_resp_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  l2_pipe_entry_t    r_pipe [LATENCY];
  l2_chan_state_e    r_state [2];
  l2_chan_state_e    w_state_nxt [2];
  logic [DATA_W-1:0] r_inst_data, r_data_data;

  logic [1:0]        w_req_valid, w_elig, w_grant, w_accept, w_resp_valid;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rd_word, w_wr_word;
  logic              w_is_store;
  l2_pipe_entry_t    w_new_entry, w_head;
  logic              w_unused;

  // Byte-offset bits and index bits above the SRAM size are ignored, so
  // addresses alias modulo DEPTH words.
  assign w_unused = ^{inst_req_addr[1:0], inst_req_addr[ADDR_W-1:IDX_W+2],
                      data_req_addr[1:0], data_req_addr[ADDR_W-1:IDX_W+2]};

  assign w_req_valid = {data_req_valid, inst_req_valid};
  assign w_head      = r_pipe[LATENCY-1];

  gelato_rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (w_elig),
    .advance (|w_accept),
    .grant   (w_grant)
  );

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    w_resp_valid[0] = rdy & w_head.valid & (w_head.chan == CHAN_INST);
    w_resp_valid[1] = rdy & w_head.valid & (w_head.chan == CHAN_DATA);
    for (int c = 0; c < 2; c++) begin
      w_elig[c]      = w_req_valid[c] & (r_state[c] == ST_IDLE);
      w_accept[c]    = rdy & w_grant[c];
      w_state_nxt[c] = r_state[c];
      case (r_state[c])
        ST_IDLE: if (w_accept[c])     w_state_nxt[c] = ST_BUSY;
        ST_BUSY: if (w_resp_valid[c]) w_state_nxt[c] = ST_IDLE;
        default:                      w_state_nxt[c] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state[0] <= ST_IDLE;
      r_state[1] <= ST_IDLE;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
    end
  end

  // Single SRAM port: the granted channel owns the address this cycle.
  assign w_idx      = w_grant[1] ? data_req_addr[2 +: IDX_W] : inst_req_addr[2 +: IDX_W];
  assign w_rd_word  = r_mem[w_idx];
  assign w_is_store = w_accept[1] & data_req_write;
  assign w_wr_word  = merge_bytes(w_rd_word, data_req_wdata, data_req_wstrb);

  assign w_new_entry.valid = |w_accept;
  assign w_new_entry.chan  = w_grant[1] ? CHAN_DATA : CHAN_INST;
  assign w_new_entry.data  = w_is_store ? w_wr_word : w_rd_word;

  // NOTE: the SRAM array has no reset; contents survive rst_n and start undefined.
  always_ff @(posedge clk) begin
    if (w_is_store) r_mem[w_idx] <= w_wr_word;
  end

  // Latency pipeline only moves while rdy is high, so a pending response is
  // delayed cycle-for-cycle by rdy-low periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else if (rdy) begin
      r_pipe[0] <= w_new_entry;
      for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // Response data is held between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst_data <= '0;
      r_data_data <= '0;
    end else begin
      if (w_resp_valid[0]) r_inst_data <= w_head.data;
      if (w_resp_valid[1]) r_data_data <= w_head.data;
    end
  end

  assign inst_req_ready  = w_accept[0];
  assign data_req_ready  = w_accept[1];
  assign inst_resp_valid = w_resp_valid[0];
  assign data_resp_valid = w_resp_valid[1];
  assign inst_resp_data  = w_resp_valid[0] ? w_head.data : r_inst_data;
  assign data_resp_data  = w_resp_valid[1] ? w_head.data : r_data_data;

endmodule
